// File: rtl/nalu_dispatch_ctrl.sv
// Top-level NAL unit dispatcher: routes each NALU to a header parser, the slice-data
// path or a skip, and handles buffer ownership, picture counting, watchdog and end of stream.
module nalu_dispatch_ctrl #(
    parameter int                       NUM_HDR        = 4,
    parameter logic [6*(NUM_HDR-1)-1:0] HDR_TYPES      = {6'd34, 6'd33, 6'd32},
    parameter int                       SLICE_TYPE_MAX = 21,
    parameter int                       FWD_W          = 4,
    parameter int                       PIC_W          = 64,
    parameter int                       TO_W           = 24,
    parameter logic [TO_W-1:0]          TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     i_ext_mem_init_done,
    input  logic [5:0]               i_nal_unit_type,
    input  logic                     i_next_nalu_detected,
    input  logic                     i_end_of_stream,
    input  logic [NUM_HDR-1:0]       i_hdr_done,
    input  logic [NUM_HDR-1:0]       i_rps_req,
    input  logic [NUM_HDR*FWD_W-1:0] i_fwd_len_hdr,
    input  logic [FWD_W-1:0]         i_fwd_len_rps,
    input  logic                     i_sd_done,
    input  logic                     i_sd_skip,
    output logic [NUM_HDR-1:0]       o_hdr_en,
    output logic [NUM_HDR-1:0]       o_rst_hdr,
    output logic                     o_rps_en,
    output logic                     o_sd_en,
    output logic                     o_rst_sd,
    output logic                     o_pass_buffer2sd,
    output logic                     o_pass_buffer2norm,
    output logic                     o_rbsp_buffer_en,
    output logic                     o_rbsp_buf_sd_en,
    output logic [FWD_W-1:0]         o_forward_len,
    output logic                     o_forward_to_next_nalu,
    output logic                     o_next_nalu_detected_clr,
    output logic [PIC_W-1:0]         o_pic_num,
    output logic [15:0]              o_skipped_cnt,
    output logic                     o_timeout_err,
    output logic                     o_stream_done,
    output logic [2:0]               o_state
);

    localparam int               K_W       = (NUM_HDR > 1) ? $clog2(NUM_HDR) : 1;
    localparam logic [K_W-1:0]   SLICE_K   = K_W'(NUM_HDR - 1);
    localparam logic [5:0]       SLICE_MAX = 6'(SLICE_TYPE_MAX);
    localparam logic [TO_W-1:0]  TO_LAST   = TIMEOUT_CYCLES - 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PARSE_HDR  = 3'd1,
        SLICE_HDR  = 3'd2,
        SLICE_DATA = 3'd3,
        FORWARD    = 3'd4,
        NEXT       = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t              state_reg;
    logic [K_W-1:0]      k_reg;
    logic [NUM_HDR-1:0]  hdr_en_reg;
    logic [NUM_HDR-1:0]  rst_hdr_reg;
    logic                rps_en_reg;
    logic                sd_en_reg;
    logic                rst_sd_reg;
    logic                pass2sd_reg;
    logic                pass2norm_reg;
    logic                rbsp_buffer_en_reg;
    logic                rbsp_buf_sd_en_reg;
    logic                forward_reg;
    logic                clr_reg;
    logic [PIC_W-1:0]    pic_num_reg;
    logic [15:0]         skipped_cnt_reg;
    logic                timeout_err_reg;
    logic                stream_done_reg;
    logic [TO_W-1:0]     wd_cnt_reg;

    logic [NUM_HDR-2:0]  type_match;
    logic [FWD_W-1:0]    hdr_len [NUM_HDR];
    logic [K_W-1:0]      match_idx;
    logic                match_any;
    logic                wd_expire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HDR - 1; gi++) begin : g_match
            assign type_match[gi] = (i_nal_unit_type == HDR_TYPES[6*gi +: 6]);
        end
        for (gi = 0; gi < NUM_HDR; gi++) begin : g_len
            assign hdr_len[gi] = i_fwd_len_hdr[gi*FWD_W +: FWD_W];
        end
    endgenerate

    // Scan from the top down so the lowest matching parser index is the one kept.
    always_comb begin
        match_idx = '0;
        match_any = |type_match;
        for (int i = NUM_HDR - 2; i >= 0; i--) begin
            if (type_match[i]) match_idx = K_W'(i);
        end
    end

    assign wd_expire = (TIMEOUT_CYCLES != '0) && (wd_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            k_reg              <= '0;
            hdr_en_reg         <= '0;
            rst_hdr_reg        <= '0;
            rps_en_reg         <= 1'b0;
            sd_en_reg          <= 1'b0;
            rst_sd_reg         <= 1'b0;
            pass2sd_reg        <= 1'b0;
            pass2norm_reg      <= 1'b0;
            rbsp_buffer_en_reg <= 1'b1;
            rbsp_buf_sd_en_reg <= 1'b0;
            forward_reg        <= 1'b0;
            clr_reg            <= 1'b0;
            pic_num_reg        <= '0;
            skipped_cnt_reg    <= '0;
            timeout_err_reg    <= 1'b0;
            stream_done_reg    <= 1'b0;
            wd_cnt_reg         <= '0;
        end else if (en) begin
            rst_hdr_reg   <= '0;
            rst_sd_reg    <= 1'b0;
            pass2sd_reg   <= 1'b0;
            pass2norm_reg <= 1'b0;
            clr_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_ext_mem_init_done && (i_nal_unit_type == HDR_TYPES[5:0])) begin
                        k_reg       <= '0;
                        hdr_en_reg  <= NUM_HDR'(1);
                        rst_hdr_reg <= NUM_HDR'(1);
                        clr_reg     <= 1'b1;
                        wd_cnt_reg  <= '0;
                        state_reg   <= PARSE_HDR;
                    end
                end
                NEXT: begin
                    if (match_any) begin
                        k_reg       <= match_idx;
                        hdr_en_reg  <= NUM_HDR'(1) << match_idx;
                        rst_hdr_reg <= NUM_HDR'(1) << match_idx;
                        wd_cnt_reg  <= '0;
                        state_reg   <= PARSE_HDR;
                    end else if (i_nal_unit_type <= SLICE_MAX) begin
                        k_reg       <= SLICE_K;
                        hdr_en_reg  <= NUM_HDR'(1) << SLICE_K;
                        rst_hdr_reg <= NUM_HDR'(1) << SLICE_K;
                        wd_cnt_reg  <= '0;
                        state_reg   <= SLICE_HDR;
                    end else begin
                        if (skipped_cnt_reg != 16'hFFFF) skipped_cnt_reg <= skipped_cnt_reg + 16'd1;
                        state_reg <= FORWARD;
                    end
                end
                PARSE_HDR, SLICE_HDR: begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    rps_en_reg <= i_rps_req[k_reg];
                    // The done flag is stale while the parser is still in its reset cycle.
                    if (!rst_hdr_reg[k_reg] && i_hdr_done[k_reg]) begin
                        hdr_en_reg <= '0;
                        rps_en_reg <= 1'b0;
                        if (state_reg == SLICE_HDR) begin
                            sd_en_reg          <= 1'b1;
                            rst_sd_reg         <= 1'b1;
                            pass2sd_reg        <= 1'b1;
                            rbsp_buffer_en_reg <= 1'b0;
                            rbsp_buf_sd_en_reg <= 1'b1;
                            wd_cnt_reg         <= '0;
                            state_reg          <= SLICE_DATA;
                        end else begin
                            state_reg <= FORWARD;
                        end
                    end else if (wd_expire) begin
                        hdr_en_reg         <= '0;
                        rps_en_reg         <= 1'b0;
                        sd_en_reg          <= 1'b0;
                        timeout_err_reg    <= 1'b1;
                        rbsp_buffer_en_reg <= 1'b1;
                        rbsp_buf_sd_en_reg <= 1'b0;
                        state_reg          <= FORWARD;
                    end
                end
                SLICE_DATA: begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    if (!rst_sd_reg && (i_sd_done || i_sd_skip)) begin
                        sd_en_reg          <= 1'b0;
                        rbsp_buffer_en_reg <= 1'b1;
                        rbsp_buf_sd_en_reg <= 1'b0;
                        state_reg          <= FORWARD;
                        if (i_sd_done) begin
                            pic_num_reg   <= pic_num_reg + 1'b1;
                            pass2norm_reg <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        hdr_en_reg         <= '0;
                        rps_en_reg         <= 1'b0;
                        sd_en_reg          <= 1'b0;
                        timeout_err_reg    <= 1'b1;
                        rbsp_buffer_en_reg <= 1'b1;
                        rbsp_buf_sd_en_reg <= 1'b0;
                        state_reg          <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (i_next_nalu_detected) begin
                        forward_reg <= 1'b0;
                        clr_reg     <= 1'b1;
                        state_reg   <= NEXT;
                    end else if (i_end_of_stream) begin
                        forward_reg     <= 1'b0;
                        stream_done_reg <= 1'b1;
                        state_reg       <= DONE;
                    end else begin
                        forward_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_forward_len = '0;
        if (rps_en_reg)       o_forward_len = i_fwd_len_rps;
        else if (|hdr_en_reg) o_forward_len = hdr_len[k_reg];
    end

    assign o_hdr_en                 = hdr_en_reg;
    assign o_rst_hdr                = rst_hdr_reg;
    assign o_rps_en                 = rps_en_reg;
    assign o_sd_en                  = sd_en_reg;
    assign o_rst_sd                 = rst_sd_reg;
    assign o_pass_buffer2sd         = pass2sd_reg;
    assign o_pass_buffer2norm       = pass2norm_reg;
    assign o_rbsp_buffer_en         = rbsp_buffer_en_reg;
    assign o_rbsp_buf_sd_en         = rbsp_buf_sd_en_reg;
    assign o_forward_to_next_nalu   = forward_reg;
    assign o_next_nalu_detected_clr = clr_reg;
    assign o_pic_num                = pic_num_reg;
    assign o_skipped_cnt            = skipped_cnt_reg;
    assign o_timeout_err            = timeout_err_reg;
    assign o_stream_done            = stream_done_reg;
    assign o_state                  = state_reg;

endmodule

// File: tb/tb_nalu_dispatch_ctrl.sv
// Directed bench for nalu_dispatch_ctrl: header, RPS, slice, skip, watchdog,
// end-of-stream, stall and mid-run reset scenarios with hand-computed expectations.
module tb_nalu_dispatch_ctrl;

    localparam int NUM_HDR = 4;
    localparam int FWD_W   = 4;
    localparam int PIC_W   = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     i_ext_mem_init_done;
    logic [5:0]               i_nal_unit_type;
    logic                     i_next_nalu_detected;
    logic                     i_end_of_stream;
    logic [NUM_HDR-1:0]       i_hdr_done;
    logic [NUM_HDR-1:0]       i_rps_req;
    logic [NUM_HDR*FWD_W-1:0] i_fwd_len_hdr;
    logic [FWD_W-1:0]         i_fwd_len_rps;
    logic                     i_sd_done;
    logic                     i_sd_skip;
    logic [NUM_HDR-1:0]       o_hdr_en;
    logic [NUM_HDR-1:0]       o_rst_hdr;
    logic                     o_rps_en;
    logic                     o_sd_en;
    logic                     o_rst_sd;
    logic                     o_pass_buffer2sd;
    logic                     o_pass_buffer2norm;
    logic                     o_rbsp_buffer_en;
    logic                     o_rbsp_buf_sd_en;
    logic [FWD_W-1:0]         o_forward_len;
    logic                     o_forward_to_next_nalu;
    logic                     o_next_nalu_detected_clr;
    logic [PIC_W-1:0]         o_pic_num;
    logic [15:0]              o_skipped_cnt;
    logic                     o_timeout_err;
    logic                     o_stream_done;
    logic [2:0]               o_state;

    int checks = 0;
    int errors = 0;

    nalu_dispatch_ctrl #(
        .NUM_HDR(NUM_HDR), .FWD_W(FWD_W), .PIC_W(PIC_W), .TO_W(24),
        .TIMEOUT_CYCLES(24'd16)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .i_ext_mem_init_done(i_ext_mem_init_done),
        .i_nal_unit_type(i_nal_unit_type),
        .i_next_nalu_detected(i_next_nalu_detected),
        .i_end_of_stream(i_end_of_stream),
        .i_hdr_done(i_hdr_done), .i_rps_req(i_rps_req),
        .i_fwd_len_hdr(i_fwd_len_hdr), .i_fwd_len_rps(i_fwd_len_rps),
        .i_sd_done(i_sd_done), .i_sd_skip(i_sd_skip),
        .o_hdr_en(o_hdr_en), .o_rst_hdr(o_rst_hdr), .o_rps_en(o_rps_en),
        .o_sd_en(o_sd_en), .o_rst_sd(o_rst_sd),
        .o_pass_buffer2sd(o_pass_buffer2sd), .o_pass_buffer2norm(o_pass_buffer2norm),
        .o_rbsp_buffer_en(o_rbsp_buffer_en), .o_rbsp_buf_sd_en(o_rbsp_buf_sd_en),
        .o_forward_len(o_forward_len), .o_forward_to_next_nalu(o_forward_to_next_nalu),
        .o_next_nalu_detected_clr(o_next_nalu_detected_clr),
        .o_pic_num(o_pic_num), .o_skipped_cnt(o_skipped_cnt),
        .o_timeout_err(o_timeout_err), .o_stream_done(o_stream_done),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse a start code from FORWARD and land in whatever NEXT dispatches to.
    task automatic dispatch(input logic [5:0] t);
        i_nal_unit_type      = t;
        i_next_nalu_detected = 1'b1;
        step();
        i_next_nalu_detected = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; i_ext_mem_init_done = 1'b0; i_nal_unit_type = 6'd0;
        i_next_nalu_detected = 1'b0; i_end_of_stream = 1'b0; i_hdr_done = '0; i_rps_req = '0;
        i_fwd_len_hdr = {4'd9, 4'd5, 4'd2, 4'd6}; i_fwd_len_rps = 4'd7;
        i_sd_done = 1'b0; i_sd_skip = 1'b0;
        step(); step();
        rst = 1'b0;
        check_val("reset_state", o_state, 3'd0);
        check_val("reset_bufen", o_rbsp_buffer_en, 1'b1);
        check_val("reset_hdr_en", o_hdr_en, 4'h0);
        check_val("reset_pic", o_pic_num, 64'd0);

        // VPS from IDLE, done after 10 cycles in PARSE_HDR
        i_nal_unit_type = 6'd32; i_ext_mem_init_done = 1'b1;
        step();
        check_val("vps_state", o_state, 3'd1);
        check_val("vps_hdr_en", o_hdr_en, 4'b0001);
        check_val("vps_rst_pulse", o_rst_hdr, 4'b0001);
        check_val("vps_clr", o_next_nalu_detected_clr, 1'b1);
        check_val("vps_fwd_len", o_forward_len, 4'd6);
        step();
        check_val("vps_rst_drop", o_rst_hdr, 4'b0000);
        repeat (8) step();
        i_hdr_done = 4'b0001;
        step();
        i_hdr_done = '0;
        check_val("vps_to_fwd", o_state, 3'd4);
        check_val("vps_hdr_off", o_hdr_en, 4'b0000);
        check_val("vps_fwd_len0", o_forward_len, 4'd0);
        step();
        check_val("fwd_flag", o_forward_to_next_nalu, 1'b1);

        // SPS with RPS request held for three cycles
        i_nal_unit_type = 6'd33; i_next_nalu_detected = 1'b1;
        step();
        check_val("next_state", o_state, 3'd5);
        check_val("next_clr", o_next_nalu_detected_clr, 1'b1);
        check_val("next_fwd_off", o_forward_to_next_nalu, 1'b0);
        i_next_nalu_detected = 1'b0;
        step();
        check_val("sps_hdr_en", o_hdr_en, 4'b0010);
        check_val("sps_len", o_forward_len, 4'd2);
        i_rps_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("rps_en_%0d", i), o_rps_en, 1'b1);
            check_val($sformatf("rps_len_%0d", i), o_forward_len, 4'd7);
        end
        i_rps_req = '0;
        step();
        check_val("rps_off", o_rps_en, 1'b0);
        check_val("sps_len_back", o_forward_len, 4'd2);
        i_hdr_done = 4'b0010;
        step();
        i_hdr_done = '0;
        check_val("sps_to_fwd", o_state, 3'd4);

        // Slice type 1: header, hand-over, slice data done
        dispatch(6'd1);
        check_val("slice_state", o_state, 3'd2);
        check_val("slice_hdr_en", o_hdr_en, 4'b1000);
        check_val("slice_len", o_forward_len, 4'd9);
        i_hdr_done = 4'b1000;
        step();
        check_val("slice_done_ignored", o_state, 3'd2);
        step();
        i_hdr_done = '0;
        check_val("sd_state", o_state, 3'd3);
        check_val("sd_en", o_sd_en, 1'b1);
        check_val("sd_rst", o_rst_sd, 1'b1);
        check_val("pass2sd", o_pass_buffer2sd, 1'b1);
        check_val("sd_bufen", o_rbsp_buffer_en, 1'b0);
        check_val("sd_bufsd", o_rbsp_buf_sd_en, 1'b1);
        i_sd_done = 1'b1;
        step();
        check_val("sd_done_ignored", o_state, 3'd3);
        check_val("pass2sd_drop", o_pass_buffer2sd, 1'b0);
        step();
        i_sd_done = 1'b0;
        check_val("sd_to_fwd", o_state, 3'd4);
        check_val("pic_1", o_pic_num, 64'd1);
        check_val("pass2norm", o_pass_buffer2norm, 1'b1);
        check_val("norm_bufen", o_rbsp_buffer_en, 1'b1);
        check_val("norm_bufsd", o_rbsp_buf_sd_en, 1'b0);
        check_val("sd_en_off", o_sd_en, 1'b0);
        step();
        check_val("pass2norm_drop", o_pass_buffer2norm, 1'b0);

        // Slice with done and skip together (done wins), then skip alone
        dispatch(6'd5);
        i_hdr_done = 4'b1000;
        step(); step();
        i_hdr_done = '0;
        step();
        i_sd_done = 1'b1; i_sd_skip = 1'b1;
        step();
        i_sd_done = 1'b0; i_sd_skip = 1'b0;
        check_val("both_pic", o_pic_num, 64'd2);
        check_val("both_norm", o_pass_buffer2norm, 1'b1);
        dispatch(6'd21);
        check_val("slice_max_state", o_state, 3'd2);
        i_hdr_done = 4'b1000;
        step(); step();
        i_hdr_done = '0;
        step();
        i_sd_skip = 1'b1;
        step();
        i_sd_skip = 1'b0;
        check_val("skip_state", o_state, 3'd4);
        check_val("skip_pic", o_pic_num, 64'd2);
        check_val("skip_norm", o_pass_buffer2norm, 1'b0);
        check_val("skip_bufen", o_rbsp_buffer_en, 1'b1);

        // Unsupported NALU and counter saturation
        dispatch(6'd39);
        check_val("sei_state", o_state, 3'd4);
        check_val("sei_hdr_en", o_hdr_en, 4'b0000);
        check_val("sei_cnt", o_skipped_cnt, 16'd1);
        force dut.skipped_cnt_reg = 16'hFFFF;
        step();
        release dut.skipped_cnt_reg;
        step();
        dispatch(6'd39);
        check_val("sat_cnt", o_skipped_cnt, 16'hFFFF);

        // PPS done arriving exactly on the timeout cycle
        dispatch(6'd34);
        check_val("pps_hdr_en", o_hdr_en, 4'b0100);
        repeat (15) step();
        check_val("pps_pre_state", o_state, 3'd1);
        i_hdr_done = 4'b0100;
        step();
        i_hdr_done = '0;
        check_val("edge_done_state", o_state, 3'd4);
        check_val("edge_done_noerr", o_timeout_err, 1'b0);

        // PPS with done never asserted
        dispatch(6'd34);
        repeat (15) step();
        check_val("to_pre_state", o_state, 3'd1);
        check_val("to_pre_err", o_timeout_err, 1'b0);
        step();
        check_val("to_state", o_state, 3'd4);
        check_val("to_hdr_off", o_hdr_en, 4'b0000);
        check_val("to_err", o_timeout_err, 1'b1);
        check_val("to_bufen", o_rbsp_buffer_en, 1'b1);
        step(); step();
        check_val("to_sticky", o_timeout_err, 1'b1);

        // Detect beats end-of-stream, stall, then end-of-stream alone
        i_nal_unit_type = 6'd39; i_next_nalu_detected = 1'b1; i_end_of_stream = 1'b1;
        step();
        check_val("det_wins", o_state, 3'd5);
        i_next_nalu_detected = 1'b0; i_end_of_stream = 1'b0;
        step();
        check_val("det_fwd", o_state, 3'd4);
        en = 1'b0; i_next_nalu_detected = 1'b1; i_end_of_stream = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("stall_state_%0d", i), o_state, 3'd4);
            check_val($sformatf("stall_clr_%0d", i), o_next_nalu_detected_clr, 1'b0);
            check_val($sformatf("stall_done_%0d", i), o_stream_done, 1'b0);
        end
        en = 1'b1; i_next_nalu_detected = 1'b0;
        step();
        check_val("eos_state", o_state, 3'd6);
        check_val("eos_done", o_stream_done, 1'b1);
        check_val("eos_fwd", o_forward_to_next_nalu, 1'b0);
        i_end_of_stream = 1'b0; i_next_nalu_detected = 1'b1;
        step(); step();
        check_val("done_hold", o_state, 3'd6);

        // Reset from DONE
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_state", o_state, 3'd0);
        check_val("rst_stream_done", o_stream_done, 1'b0);
        check_val("rst_pic", o_pic_num, 64'd0);
        check_val("rst_err", o_timeout_err, 1'b0);
        check_val("rst_skipped", o_skipped_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
